// File: rtl/mandelbrot_stream_engine.sv
// -----------------------------------------------------------------------------
// mandelbrot_stream_engine
//
// Fixed-point Mandelbrot frame generator with an AXI4-Stream video output.
// A single iteration engine performs one z-update per clock. Pixels are
// produced in raster order, X_SIZE pixels per line, Y_SIZE lines per frame.
// The viewport, iteration limit and palette are sampled at the start of each
// frame, so changes mid-frame only take effect on the next frame.
//
// Ports
//   aclk               clock
//   areset             synchronous reset, active-high
//   cfg_x0             signed real coordinate of pixel x=0        (DW bits)
//   cfg_y0             signed imaginary coordinate of line y=0    (DW bits)
//   cfg_step           signed per-pixel step on both axes         (DW bits)
//   cfg_max_iter       iteration limit N, N >= 1                  (ITER_W bits)
//   cfg_palette        0 = gradient, 1 = grey
//   out_stream_tdata   {R,G,B,8'h00}
//   out_stream_tkeep   constant 4'hF
//   out_stream_tlast   last pixel of the frame
//   out_stream_tuser   first pixel of the frame
//   out_stream_tvalid  pixel valid
//   out_stream_tready  sink ready
//   frame_done         high in the cycle the tlast beat is accepted
//
// ITER_W must be at least 8 (the colour uses the low byte of the count) and
// 1 <= FRAC < DW.
// -----------------------------------------------------------------------------
module mandelbrot_stream_engine #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480,
    parameter int DW     = 32,
    parameter int FRAC   = 24,
    parameter int ITER_W = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic signed [DW-1:0] cfg_x0,
    input  logic signed [DW-1:0] cfg_y0,
    input  logic signed [DW-1:0] cfg_step,
    input  logic [ITER_W-1:0]    cfg_max_iter,
    input  logic                 cfg_palette,
    output logic [31:0]          out_stream_tdata,
    output logic [3:0]           out_stream_tkeep,
    output logic                 out_stream_tlast,
    output logic                 out_stream_tuser,
    output logic                 out_stream_tvalid,
    input  logic                 out_stream_tready,
    output logic                 frame_done
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;

    // |z|^2 bound of 4.0 expressed in the 2*FRAC fractional format of the
    // squared terms; one extra bit so the sum of two squares cannot overflow.
    localparam logic [2*DW:0] ESC_LIMIT = (2*DW+1)'(4) << (2*FRAC);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        ITER = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [XW-1:0]        x_reg;
    logic [YW-1:0]        y_reg;

    // Per-frame shadow copies of the configuration. The imaginary origin
    // needs no shadow: it is only read at pixel (0,0) and thereafter lives
    // on in c_im_reg, which is advanced by the step at each new line.
    logic signed [DW-1:0] x0_reg;
    logic signed [DW-1:0] step_reg;
    logic [ITER_W-1:0]    max_iter_reg;
    logic                 palette_reg;

    logic signed [DW-1:0] c_re_reg;
    logic signed [DW-1:0] c_im_reg;
    logic signed [DW-1:0] zr_reg;
    logic signed [DW-1:0] zi_reg;
    logic [ITER_W-1:0]    iter_reg;

    logic [31:0]          tdata_reg;
    logic                 tlast_reg;
    logic                 tuser_reg;
    logic                 tvalid_reg;

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic signed [2*DW-1:0] zr_ext;
    logic signed [2*DW-1:0] zi_ext;
    logic signed [2*DW-1:0] zr2;
    logic signed [2*DW-1:0] zi2;
    logic signed [2*DW-1:0] zrzi;
    logic [2*DW:0]          mag;
    logic                   escaped;
    logic                   iter_last;
    logic signed [DW-1:0]   zr_upd;
    logic signed [DW-1:0]   zi_upd;

    assign zr_ext = {{DW{zr_reg[DW-1]}}, zr_reg};
    assign zi_ext = {{DW{zi_reg[DW-1]}}, zi_reg};
    assign zr2    = zr_ext * zr_ext;
    assign zi2    = zi_ext * zi_ext;
    assign zrzi   = zr_ext * zi_ext;

    // Both squares are non-negative, so a zero-extended sum is exact.
    assign mag       = {1'b0, zr2} + {1'b0, zi2};
    assign escaped   = (mag > ESC_LIMIT);
    assign iter_last = (iter_reg == max_iter_reg - ITER_W'(1));

    // Arithmetic shifts floor toward -inf; the size cast wraps to DW bits.
    // Doubling before the shift can only disturb the top product bit, which
    // lies above the DW bits kept.
    assign zr_upd = DW'((zr2 - zi2) >>> FRAC) + c_re_reg;
    assign zi_upd = DW'((zrzi <<< 1) >>> FRAC) + c_im_reg;

    // ------------------------------------------------------------------
    // Raster position helpers
    // ------------------------------------------------------------------
    logic last_x;
    logic last_y;
    logic first_pix;

    assign last_x    = (x_reg == XW'(X_SIZE - 1));
    assign last_y    = (y_reg == YW'(Y_SIZE - 1));
    assign first_pix = (x_reg == '0) && (y_reg == '0);

    function automatic logic [23:0] colour(input logic [ITER_W-1:0] i,
                                           input logic              grey);
        logic [7:0] i8;
        i8 = i[7:0];
        if (grey) begin
            return {i8, i8, i8};
        end
        return {i8, {i8[6:0], 1'b0}, 8'd255 - i8};
    endfunction

    // ------------------------------------------------------------------
    // State machine: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD: state_next = ITER;
            ITER: if (escaped || iter_last) state_next = OUT;
            OUT:  if (out_stream_tready) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg    <= LOAD;
            x_reg        <= '0;
            y_reg        <= '0;
            x0_reg       <= '0;
            step_reg     <= '0;
            max_iter_reg <= '0;
            palette_reg  <= 1'b0;
            c_re_reg     <= '0;
            c_im_reg     <= '0;
            zr_reg       <= '0;
            zi_reg       <= '0;
            iter_reg     <= '0;
            tdata_reg    <= '0;
            tlast_reg    <= 1'b0;
            tuser_reg    <= 1'b0;
            tvalid_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD: begin
                    if (first_pix) begin
                        x0_reg       <= cfg_x0;
                        step_reg     <= cfg_step;
                        max_iter_reg <= cfg_max_iter;
                        palette_reg  <= cfg_palette;
                        c_re_reg     <= cfg_x0;
                        c_im_reg     <= cfg_y0;
                    end else if (x_reg == '0) begin
                        c_re_reg <= x0_reg;
                        c_im_reg <= c_im_reg + step_reg;
                    end else begin
                        c_re_reg <= c_re_reg + step_reg;
                    end
                    zr_reg   <= '0;
                    zi_reg   <= '0;
                    iter_reg <= '0;
                end

                ITER: begin
                    if (escaped || iter_last) begin
                        // Escape wins over the limit: escaping on the last
                        // allowed step still reports the iteration count.
                        tdata_reg  <= escaped ? {colour(iter_reg, palette_reg), 8'h00}
                                              : 32'h0;
                        tlast_reg  <= last_x && last_y;
                        tuser_reg  <= first_pix;
                        tvalid_reg <= 1'b1;
                    end else begin
                        zr_reg   <= zr_upd;
                        zi_reg   <= zi_upd;
                        iter_reg <= iter_reg + ITER_W'(1);
                    end
                end

                OUT: begin
                    if (out_stream_tready) begin
                        tvalid_reg <= 1'b0;
                        if (last_x) begin
                            x_reg <= '0;
                            y_reg <= last_y ? '0 : y_reg + YW'(1);
                        end else begin
                            x_reg <= x_reg + XW'(1);
                        end
                    end
                end

                default: ;
            endcase
        end
    end

    assign out_stream_tdata  = tdata_reg;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_reg;
    assign out_stream_tuser  = tuser_reg;
    assign out_stream_tvalid = tvalid_reg;
    assign frame_done        = tvalid_reg && out_stream_tready && tlast_reg;

endmodule

// File: tb/tb_mandelbrot_stream_engine.sv
// -----------------------------------------------------------------------------
// tb_mandelbrot_stream_engine
//
// Self-checking bench for mandelbrot_stream_engine on a 4x2 frame. Each frame's
// expected beats come from a reference model that iterates z = z^2 + c with
// plain 64-bit integer arithmetic for every pixel coordinate x0 + x*step,
// y0 + y*step. The bench drives tready (steady, stalled, or random) and
// compares every valid beat, the frame_done pulse and the cycles per pixel.
// -----------------------------------------------------------------------------
module tb_mandelbrot_stream_engine;

    localparam int X_SIZE = 4;
    localparam int Y_SIZE = 2;
    localparam int DW     = 32;
    localparam int FRAC   = 24;
    localparam int ITER_W = 8;
    localparam int NPIX   = X_SIZE * Y_SIZE;

    logic               aclk = 1'b0;
    logic               areset;
    logic signed [31:0] cfg_x0;
    logic signed [31:0] cfg_y0;
    logic signed [31:0] cfg_step;
    logic [7:0]         cfg_max_iter;
    logic               cfg_palette;
    logic [31:0]        tdata;
    logic [3:0]         tkeep;
    logic               tlast;
    logic               tuser;
    logic               tvalid;
    logic               tready;
    logic               frame_done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] first_tdata;
    logic [31:0] exp_data [NPIX];
    int          exp_cycles [NPIX];

    mandelbrot_stream_engine #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .DW     (DW),
        .FRAC   (FRAC),
        .ITER_W (ITER_W)
    ) dut (
        .aclk              (aclk),
        .areset            (areset),
        .cfg_x0            (cfg_x0),
        .cfg_y0            (cfg_y0),
        .cfg_step          (cfg_step),
        .cfg_max_iter      (cfg_max_iter),
        .cfg_palette       (cfg_palette),
        .out_stream_tdata  (tdata),
        .out_stream_tkeep  (tkeep),
        .out_stream_tlast  (tlast),
        .out_stream_tuser  (tuser),
        .out_stream_tvalid (tvalid),
        .out_stream_tready (tready),
        .frame_done        (frame_done)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Returns the index of the first iterate with |z|^2 > 4, or n if none of
    // z_0 .. z_(n-1) escapes.
    function automatic int escape_count(input int cre, input int cim, input int n);
        int          zr;
        int          zi;
        longint      zr2;
        longint      zi2;
        longint      p;
        logic [64:0] mag;
        zr = 0;
        zi = 0;
        for (int i = 0; i < n; i++) begin
            zr2 = longint'(zr) * longint'(zr);
            zi2 = longint'(zi) * longint'(zi);
            mag = {1'b0, zr2} + {1'b0, zi2};
            if (mag > (65'd4 << 48)) return i;
            if (i == n - 1) return n;
            p  = 2 * longint'(zr) * longint'(zi);
            zi = int'(p >>> FRAC) + cim;
            zr = int'((zr2 - zi2) >>> FRAC) + cre;
        end
        return n;
    endfunction

    function automatic logic [31:0] pixel_word(input int res, input int n, input logic grey);
        logic [7:0] i8;
        logic [7:0] g8;
        i8 = 8'(res);
        g8 = 8'(2 * res);
        if (res == n) return 32'h0;
        if (grey) return {i8, i8, i8, 8'h00};
        return {i8, g8, 8'd255 - i8, 8'h00};
    endfunction

    // Snapshot the current configuration into the expected frame.
    task automatic build_expected();
        int res;
        int cre;
        int cim;
        int n;
        n = int'(cfg_max_iter);
        for (int p = 0; p < NPIX; p++) begin
            cre = int'(cfg_x0) + (p % X_SIZE) * int'(cfg_step);
            cim = int'(cfg_y0) + (p / X_SIZE) * int'(cfg_step);
            res = escape_count(cre, cim, n);
            exp_data[p]   = pixel_word(res, n, cfg_palette);
            exp_cycles[p] = 2 + ((res == n) ? n : res + 1);
        end
    endtask

    // Collects one frame. stall_beat: beat held off for 10 cycles (-1 none);
    // pal_beat: toggle cfg_palette once this many beats are accepted (-1 none);
    // rand_ready: random back-pressure; stop_after: return early once this
    // many beats are committed (-1 = full frame).
    task automatic run_frame(input int stall_beat, input int pal_beat,
                             input bit rand_ready, input int stop_after);
        int b;
        int stall_cnt;
        int guard;
        int last_cyc;
        int limit;
        bit stalled;
        b = 0;
        stall_cnt = 0;
        guard = 0;
        last_cyc = 0;
        stalled = 1'b0;
        build_expected();
        limit = 2 * NPIX * (int'(cfg_max_iter) + 2) + 200;
        while (b < NPIX) begin
            @(negedge aclk);
            guard++;
            if (guard > limit) begin
                check_eq("frame_timeout", 32'(b), 32'(NPIX));
                tready = 1'b1;
                return;
            end
            if (tvalid) begin
                if (b == stall_beat && stall_cnt < 10) begin
                    tready = 1'b0;
                    stall_cnt++;
                end else if (rand_ready) begin
                    tready = ($urandom_range(0, 3) != 0);
                end else begin
                    tready = 1'b1;
                end
            end
            #1;
            if (!tvalid) begin
                check_eq("frame_done_idle", 32'(frame_done), 32'h0);
                continue;
            end
            check_eq("tdata", tdata, exp_data[b]);
            check_eq("tuser", 32'(tuser), 32'(b == 0));
            check_eq("tlast", 32'(tlast), 32'(b == NPIX - 1));
            check_eq("tkeep", 32'(tkeep), 32'hF);
            if (!tready) begin
                stalled = 1'b1;
                check_eq("frame_done_stall", 32'(frame_done), 32'h0);
                continue;
            end
            check_eq("frame_done", 32'(frame_done), 32'(b == NPIX - 1));
            if (b == 0) first_tdata = tdata;
            if (b > 0 && !stalled) check_eq("pixel_cycles", 32'(cyc - last_cyc), 32'(exp_cycles[b]));
            last_cyc = cyc;
            stalled = 1'b0;
            b++;
            if (b == pal_beat) cfg_palette = ~cfg_palette;
            if (b == stop_after) return;
        end
        tready = 1'b1;
    endtask

    initial begin
        // 1: reset 3 cycles, c = 2.0 escapes at i=2
        areset       = 1'b1;
        tready       = 1'b1;
        cfg_x0       = 32'h0200_0000;
        cfg_y0       = 32'h0;
        cfg_step     = 32'h0;
        cfg_max_iter = 8'd16;
        cfg_palette  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #1;
        check_eq("reset_tvalid", 32'(tvalid), 32'h0);
        check_eq("reset_tdata", tdata, 32'h0);
        check_eq("reset_tlast", 32'(tlast), 32'h0);
        check_eq("reset_tuser", 32'(tuser), 32'h0);
        check_eq("reset_frame_done", 32'(frame_done), 32'h0);
        check_eq("reset_tkeep", 32'(tkeep), 32'hF);
        areset = 1'b0;
        run_frame(-1, -1, 1'b0, -1);
        check_eq("t1_first_beat", first_tdata, 32'h0204_FD00);

        // 2: c = 0 never escapes, 16 iterations per pixel
        cfg_x0 = 32'h0;
        run_frame(-1, -1, 1'b0, -1);
        check_eq("t2_first_beat", first_tdata, 32'h0);

        // 3: |z|^2 == 4 exactly is inside; one LSB further out escapes at i=1
        cfg_x0       = 32'hFE00_0000;
        cfg_max_iter = 8'd20;
        run_frame(-1, -1, 1'b0, -1);
        check_eq("t3_boundary_inside", first_tdata, 32'h0);
        cfg_x0 = 32'hFDFF_FFFF;
        run_frame(-1, -1, 1'b0, -1);
        check_eq("t3_boundary_escape", first_tdata, 32'h0102_FE00);

        // 4: back-pressure for 10 cycles on beat 2
        cfg_x0       = 32'hFE80_0000;
        cfg_y0       = 32'hFF80_0000;
        cfg_step     = 32'h0080_0000;
        cfg_max_iter = 8'd16;
        run_frame(2, -1, 1'b0, -1);

        // 5: palette change mid-frame only affects the next frame
        run_frame(-1, 3, 1'b0, -1);
        cfg_x0   = 32'h0200_0000;
        cfg_y0   = 32'h0;
        cfg_step = 32'h0;
        run_frame(-1, -1, 1'b0, -1);
        check_eq("t5_grey_first_beat", first_tdata, 32'h0202_0200);

        // 6: reset while pixel 5 (c = -1.0, never escapes) is iterating
        cfg_x0      = 32'hFE80_0000;
        cfg_y0      = 32'hFF80_0000;
        cfg_step    = 32'h0080_0000;
        cfg_palette = 1'b0;
        run_frame(-1, -1, 1'b0, 5);
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        #1;
        check_eq("t6_reset_tvalid", 32'(tvalid), 32'h0);
        check_eq("t6_reset_frame_done", 32'(frame_done), 32'h0);
        areset = 1'b0;
        run_frame(-1, -1, 1'b0, -1);
        check_eq("t6_restart_first_beat", first_tdata, 32'h0306_FC00);

        // Random viewports, limits, palettes and back-pressure
        for (int f = 0; f < 6; f++) begin
            cfg_x0       = 32'($urandom_range(0, 58720256)) - 32'd41943040;
            cfg_y0       = 32'($urandom_range(0, 33554432)) - 32'd16777216;
            cfg_step     = 32'($urandom_range(0, 8388608));
            cfg_max_iter = 8'($urandom_range(1, 40));
            cfg_palette  = 1'($urandom_range(0, 1));
            run_frame(-1, -1, 1'b1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
